// File: rtl/lpf_channel_scheduler.sv
// One shared first-order low-pass datapath, time-multiplexed round-robin over N_CH channels.
// Build option LPF_ROUND_EN: round-half-up shifts with saturation (default: plain truncating shifts).

module lpf_ch_slot #(
  parameter int W = 20
) (
  input  logic         qzt_clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] vin,
  input  logic         clr,
  input  logic         ovr_clr,
  output logic         pending,
  output logic         overrun,
  output logic [W-1:0] sample
);
  logic tick_old;
  logic edge_det;

  assign edge_det = tick & ~tick_old;

  // An edge landing while the arbiter takes the old sample loses nothing, so no overrun then.
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      tick_old <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      sample   <= '0;
    end else begin
      tick_old <= tick;
      if (edge_det) sample <= vin;
      pending <= edge_det | (pending & ~clr);
      overrun <= (edge_det & pending & ~clr) | (overrun & ~ovr_clr);
    end
  end
endmodule

module lpf_channel_scheduler #(
  parameter  int N_CH = 4,
  parameter  int W    = 20,
  parameter  int KW   = 4,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic                qzt_clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     ch_tick,
  input  logic [N_CH*W-1:0]   vin_bus,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [KW-1:0]       cfg_k,
  input  logic                ovr_clr,
  output logic signed [W-1:0] vout,
  output logic [CW-1:0]       vout_ch,
  output logic                vout_valid,
  output logic [N_CH-1:0]     overrun,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ARB, CALC, WRITE} state_t;

`ifdef LPF_ROUND_EN
  localparam int AW    = W + 2;
  localparam bit ROUND = 1'b1;
`else
  localparam int AW    = W + 1;
  localparam bit ROUND = 1'b0;
`endif
  localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  state_t                 state_q, state_d;
  logic [N_CH-1:0]        pend, arb_clr;
  logic [N_CH-1:0][W-1:0] samp;
  logic signed [W-1:0]    y_mem [N_CH];
  logic [KW-1:0]          k_mem [N_CH];
  logic [CW-1:0]          rr_q, pick, ch_q;
  logic signed [W-1:0]    x_q, yv_q, res;
  logic [KW-1:0]          k_q;
  logic signed [AW-1:0]   xe, ye, half, xs, ys, acc_d, acc_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_slot
    lpf_ch_slot #(.W(W)) u_slot (
      .qzt_clk (qzt_clk),
      .rst     (rst),
      .tick    (ch_tick[c]),
      .vin     (vin_bus[c*W +: W]),
      .clr     (arb_clr[c]),
      .ovr_clr (ovr_clr),
      .pending (pend[c]),
      .overrun (overrun[c]),
      .sample  (samp[c])
    );
  end

  // First pending channel scanning upward from the RR pointer, wrapping at N_CH.
  always_comb begin
    logic found;
    pick  = rr_q;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      int j;
      j = int'(rr_q) + i;
      if (j >= N_CH) j = j - N_CH;
      if (!found && pend[j]) begin
        pick  = CW'(j);
        found = 1'b1;
      end
    end
  end

  assign arb_clr = (state_q == ARB) ? ({{(N_CH-1){1'b0}}, 1'b1} << pick) : '0;
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pend) state_d = ARB;
      ARB:     state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   state_d = (|pend) ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xe   = {{(AW-W){x_q[W-1]}}, x_q};
    ye   = {{(AW-W){yv_q[W-1]}}, yv_q};
    half = '0;
    if (ROUND && k_q != '0) half = AW'(1) << (k_q - 1'b1);
    xs    = (xe + half) >>> k_q;
    ys    = (ye + half) >>> k_q;
    acc_d = xs + ye - ys;
  end

  // Truncating shifts cannot leave the W-bit range, so the clamp only ever engages when rounding.
  always_comb begin
    res = acc_q[W-1:0];
    if (acc_q > SMAX)      res = SMAX[W-1:0];
    else if (acc_q < SMIN) res = SMIN[W-1:0];
  end

  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      ch_q       <= '0;
      x_q        <= '0;
      yv_q       <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      vout       <= '0;
      vout_ch    <= '0;
      vout_valid <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        y_mem[c] <= '0;
        k_mem[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      vout_valid <= 1'b0;
      if (cfg_we && int'(cfg_ch) < N_CH) k_mem[cfg_ch] <= cfg_k;
      case (state_q)
        ARB: begin
          ch_q <= pick;
          x_q  <= samp[pick];
          k_q  <= k_mem[pick];
          yv_q <= y_mem[pick];
          rr_q <= (int'(pick) == N_CH-1) ? '0 : pick + 1'b1;
        end
        CALC: acc_q <= acc_d;
        WRITE: begin
          y_mem[ch_q] <= res;
          vout        <= res;
          vout_ch     <= ch_q;
          vout_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Bench for lpf_channel_scheduler: directed vector table, corner-case sequences, random bursts vs model.
`timescale 1ns/1ps
module tb_lpf_channel_scheduler;
  localparam int N_CH = 4;
  localparam int W    = 20;
  localparam int KW   = 4;
  localparam int CW   = 2;
  localparam int XMAX = (1 << (W-1)) - 1;

  logic                qzt_clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_CH-1:0]     ch_tick = '0;
  logic [N_CH*W-1:0]   vin_bus = '0;
  logic                cfg_we = 1'b0;
  logic [CW-1:0]       cfg_ch = '0;
  logic [KW-1:0]       cfg_k = '0;
  logic                ovr_clr = 1'b0;
  logic signed [W-1:0] vout;
  logic [CW-1:0]       vout_ch;
  logic                vout_valid;
  logic [N_CH-1:0]     overrun;
  logic                busy;

  always #5 qzt_clk = ~qzt_clk;

  lpf_channel_scheduler #(.N_CH(N_CH), .W(W), .KW(KW)) dut (
    .qzt_clk(qzt_clk), .rst(rst), .ch_tick(ch_tick), .vin_bus(vin_bus),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_k(cfg_k), .ovr_clr(ovr_clr),
    .vout(vout), .vout_ch(vout_ch), .vout_valid(vout_valid),
    .overrun(overrun), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int ymod [N_CH];
  int kmod [N_CH];
  int rrmod;

  function automatic int shr(int v, int k);
`ifdef LPF_ROUND_EN
    if (k == 0) return v;
    return (v + (1 << (k - 1))) >>> k;
`else
    return v >>> k;
`endif
  endfunction

  function automatic int lpf(int x, int y, int k);
    int a;
    a = shr(x, k) + y - shr(y, k);
    if (a > XMAX) a = XMAX;
    if (a < -XMAX - 1) a = -XMAX - 1;
    return a;
  endfunction

  task automatic step();
    @(posedge qzt_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_tick = '0; cfg_we = 1'b0; ovr_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < N_CH; c++) begin ymod[c] = 0; kmod[c] = 0; end
    rrmod = 0;
  endtask

  task automatic write_k(input int ch, input int k);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_k = KW'(k);
    step();
    cfg_we = 1'b0;
    kmod[ch] = k;
  endtask

  task automatic fire(input logic [N_CH-1:0] mask, input int xs[N_CH]);
    for (int c = 0; c < N_CH; c++) vin_bus[c*W +: W] = W'(xs[c]);
    ch_tick = mask;
    step();
    ch_tick = '0;
  endtask

  task automatic fire1(input int ch, input int x);
    int xs[N_CH];
    for (int c = 0; c < N_CH; c++) xs[c] = 0;
    xs[ch] = x;
    fire(N_CH'(1) << ch, xs);
  endtask

  task automatic wait_valid(output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      if (vout_valid) got = 1'b1;
    end
  endtask

  task automatic expect_out(input string name, input int ch, input int val, output int cyc);
    bit got;
    wait_valid(got, cyc);
    chk({name, "_valid"}, int'(got), 1);
    chk({name, "_ch"}, int'(vout_ch), ch);
    chk({name, "_val"}, int'(vout), val);
    ymod[ch] = val;
  endtask

  typedef struct { int ch; int k; int x; int exp_t; int exp_r; } vec_t;
  vec_t tbl [9];

  initial begin
    int cyc, e, n, cnt;
    int xs[N_CH];
    int ord[N_CH];
    logic [N_CH-1:0] mask;

    tbl[0] = '{0, 2, 1000, 250, 250};
    tbl[1] = '{0, 2, 1000, 438, 437};
    tbl[2] = '{0, 2, 1000, 579, 578};
    tbl[3] = '{0, 2, 1000, 685, 683};
    tbl[4] = '{1, 1, -1001, -501, -500};
    tbl[5] = '{1, 0, 77, 77, 77};
    tbl[6] = '{3, 15, 32767, 0, 1};
    tbl[7] = '{2, 0, XMAX, XMAX, XMAX};
    tbl[8] = '{2, 1, -XMAX - 1, 0, -1};

    // reset values while rst is held
    rst = 1'b1;
    step();
    step();
    chk("rst_vout", int'(vout), 0);
    chk("rst_vout_ch", int'(vout_ch), 0);
    chk("rst_valid", int'(vout_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
`ifdef LPF_ROUND_EN
      e = tbl[i].exp_r;
`else
      e = tbl[i].exp_t;
`endif
      write_k(tbl[i].ch, tbl[i].k);
      fire1(tbl[i].ch, tbl[i].x);
      expect_out($sformatf("tbl%0d", i), tbl[i].ch, e, cyc);
      chk($sformatf("tbl%0d_latency", i), cyc, 4);
      step();
      chk($sformatf("tbl%0d_pulse", i), int'(vout_valid), 0);
      chk($sformatf("tbl%0d_idle", i), int'(busy), 0);
    end

    // all four strobes together: served 0..3, one result every three cycles
    do_reset();
    for (int c = 0; c < N_CH; c++) xs[c] = c * 10;
    fire('1, xs);
    for (int c = 0; c < N_CH; c++) begin
      expect_out($sformatf("all4_%0d", c), c, c * 10, cyc);
      chk($sformatf("all4_gap%0d", c), cyc, (c == 0) ? 4 : 3);
    end

    // ch1 strobed twice while ch0 is in flight: newer sample wins, overrun flagged
    do_reset();
    vin_bus[0*W +: W] = W'(5);
    ch_tick = 4'b0001; step();
    vin_bus[1*W +: W] = W'(100);
    ch_tick = 4'b0010; step();
    ch_tick = 4'b0000; step();
    vin_bus[1*W +: W] = W'(200);
    ch_tick = 4'b0010; step();
    ch_tick = 4'b0000;
    expect_out("ovr_ch0", 0, 5, cyc);
    expect_out("ovr_ch1", 1, 200, cyc);
    chk("ovr_single", int'(vout_valid), 1);
    step();
    chk("ovr_no_extra", int'(vout_valid), 0);
    chk("ovr_set", int'(overrun), 2);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);

    // k rewritten while ch2 is in CALC: applies only to the next service
    do_reset();
    write_k(2, 1);
    fire1(2, 800);
    expect_out("cfg_first", 2, lpf(800, 0, 1), cyc);
    fire1(2, 800);
    step();
    chk("cfg_busy", int'(busy), 1);
    step();
    e = lpf(800, ymod[2], 1);
    write_k(2, 3);
    expect_out("cfg_oldk", 2, e, cyc);
    fire1(2, 800);
    expect_out("cfg_newk", 2, lpf(800, ymod[2], 3), cyc);

    // reset during CALC: result dropped, channel state cleared
    fire1(2, 800);
    step();
    step();
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < N_CH; c++) begin ymod[c] = 0; kmod[c] = 0; end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin step(); if (vout_valid) cnt++; end
    chk("rstmid_no_valid", cnt, 0);
    chk("rstmid_busy", int'(busy), 0);
    write_k(2, 1);
    fire1(2, 0);
    expect_out("rstmid_y_cleared", 2, 0, cyc);

    // random bursts against the model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++) write_k($urandom_range(N_CH - 1), $urandom_range(15));
      mask = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int c = 0; c < N_CH; c++) xs[c] = int'($urandom_range(2 * XMAX)) - XMAX;
      fire(mask, xs);
      n = 0;
      for (int i = 0; i < N_CH; i++) begin
        int c;
        c = (rrmod + i) % N_CH;
        if (mask[c]) begin ord[n] = c; n++; end
      end
      for (int j = 0; j < n; j++)
        expect_out($sformatf("rnd%0d_%0d", it, j), ord[j], lpf(xs[ord[j]], ymod[ord[j]], kmod[ord[j]]), cyc);
      rrmod = (ord[n-1] + 1) % N_CH;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
